// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS core: memory-port FSM states,
// primary opcode values and bit positions inside the sticky err vector.
// Latency: n/a. Backpressure: n/a.
package mips_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mp_state_t;

  // Primary opcode field (insn[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // This core decodes JR from a private primary opcode instead of an R-type funct.
  localparam logic [5:0] OP_JR    = 6'h3F;

  // Sticky error flag positions.
  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_MISALIGN = 1;

  function automatic logic [5:0] opcode_of(input logic [31:0] insn);
    return insn[31:26];
  endfunction

endpackage

// File: rtl/mem_port_timer.sv
// Access watchdog: counts BUSY cycles down from TIMEOUT-1 and flags expiry at zero.
// Latency: expire is combinational from the count; load/dec take effect next edge.
// Backpressure: none; the owner gates expire with its own BUSY state.
//
// Ports: clk, reset_n (async active-low), load (restart at TIMEOUT-1),
//        dec (one more BUSY cycle without ack), expire (count is zero).
module mem_port_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count;

  // Loading TIMEOUT-1 and expiring at zero gives exactly TIMEOUT BUSY cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(TIMEOUT - 1);
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/mem_port_unit.sv
// Memory-side stage of the multicycle controller: turns memread/memwrite into
// single-port bus transfers and owns IR and MDR.
// Latency: request one cycle after command; capture visible the cycle after ack.
// Backpressure: stall holds the controller while a command is pending or in flight.
//
// Ports:
//   controller : memread, memwrite, IorD, IR_write, pc, alu_out, wdata -> ir, opcode, mdr, stall, err
//   memory bus : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack
module mem_port_unit
  import mips_mc_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          memread,
  input  logic          memwrite,
  input  logic          IorD,
  input  logic          IR_write,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] ir,
  output logic [5:0]    opcode,
  output logic [DW-1:0] mdr,
  output logic          stall,
  output logic [1:0]    err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  mp_state_t     state, state_nxt;
  logic          cmd;
  logic [AW-1:0] addr_sel;
  logic          misaligned;
  logic          we_q;
  logic          dst_q;
  logic          expire;

  logic          issue;
  logic          misalign_hit;
  logic          ack_hit;
  logic          tmo_hit;

  assign cmd        = memread | memwrite;
  assign addr_sel   = IorD ? alu_out : pc;
  assign misaligned = (addr_sel[1:0] != 2'b00);

  // Combinational so the controller freezes in the very cycle it issues the
  // command; forced low in reset so a held command cannot freeze it there.
  assign stall = reset_n & (((state == IDLE) & cmd) | (state == BUSY));

  assign opcode = opcode_of(ir[31:0]);

  mem_port_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (issue),
    .dec     ((state == BUSY) & ~mem_ack),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE ignores the still-held command, so the controller advances exactly
  // once per access. An ack on the expiry edge wins over the timeout.
  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    misalign_hit = 1'b0;
    ack_hit      = 1'b0;
    tmo_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd) begin
          if (misaligned) begin
            misalign_hit = 1'b1;
            state_nxt    = DONE;
          end else begin
            issue     = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (expire) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir        <= '0;
      mdr       <= '0;
      err       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      dst_q     <= 1'b0;
    end else begin
      // Command attributes are latched for every accepted command; memwrite
      // wins over memread, which suppresses any read capture.
      if (issue || misalign_hit) begin
        we_q      <= memwrite;
        dst_q     <= IR_write;
        mem_wdata <= wdata;
      end
      if (issue) begin
        mem_req  <= 1'b1;
        mem_we   <= memwrite;
        mem_addr <= {addr_sel[AW-1:2], 2'b00};
      end
      if (misalign_hit) begin
        err[ERR_MISALIGN] <= 1'b1;
      end
      if (ack_hit) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (!we_q) begin
          if (dst_q) begin
            ir <= mem_rdata;
          end else begin
            mdr <= mem_rdata;
          end
        end
      end
      if (tmo_hit) begin
        mem_req          <= 1'b0;
        mem_we           <= 1'b0;
        err[ERR_TIMEOUT] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_unit.sv
module tb_mem_port_unit;

  localparam int TMO = 4;

  logic        clk;
  logic        reset_n;
  logic        memread, memwrite, IorD, IR_write;
  logic [31:0] pc, alu_out, wdata;
  logic [31:0] ir, mdr, mem_addr, mem_wdata, mem_rdata;
  logic [5:0]  opcode;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [1:0]  err;

  mem_port_unit #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .memread   (memread),
    .memwrite  (memwrite),
    .IorD      (IorD),
    .IR_write  (IR_write),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .ir        (ir),
    .opcode    (opcode),
    .mdr       (mdr),
    .stall     (stall),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [1:0]  err;
    int          stall_n;
    int          req_n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ir, m_mdr;
  logic [1:0]  m_err;
  int          n_vec, n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One controller access. ack_at = BUSY cycle (1-based) that carries mem_ack;
  // 0 or anything above TMO means the bus never answers in time.
  task automatic do_access(input logic rd, input logic wr, input logic iord, input logic irw,
                           input logic [31:0] pcv, input logic [31:0] aluv, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdat);
    exp_t        e, got;
    logic [31:0] a;
    int          st_n, rq_n;
    bit          done;
    a = iord ? aluv : pcv;
    if (a[1:0] != 2'b00) begin
      m_err[1]  = 1'b1;
      e.stall_n = 1;
      e.req_n   = 0;
    end else if (ack_at >= 1 && ack_at <= TMO) begin
      e.stall_n = 1 + ack_at;
      e.req_n   = ack_at;
      if (!wr) begin
        if (irw) m_ir = rdat;
        else     m_mdr = rdat;
      end
    end else begin
      m_err[0]  = 1'b1;
      e.stall_n = 1 + TMO;
      e.req_n   = TMO;
    end
    e.ir  = m_ir;
    e.mdr = m_mdr;
    e.err = m_err;
    sb.push_back(e);

    @(posedge clk); #1;
    memread = rd; memwrite = wr; IorD = iord; IR_write = irw;
    pc = pcv; alu_out = aluv; wdata = wd;
    st_n = 0; rq_n = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
      end else begin
        st_n++;
        if (mem_req) begin
          rq_n++;
          check("bus_addr", mem_addr, {a[31:2], 2'b00});
          check("bus_we", mem_we, wr);
          check("bus_wdata", mem_wdata, wd);
          if (rq_n == ack_at) begin
            mem_ack = 1'b1;
            mem_rdata = rdat;
          end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end
    if (!done) check("done_reached", 0, 1);
    got = sb.pop_front();
    check("ir", ir, got.ir);
    check("opcode", opcode, got.ir[31:26]);
    check("mdr", mdr, got.mdr);
    check("err", err, got.err);
    check("req_in_done", mem_req, 0);
    check("stall_cycles", st_n, got.stall_n);
    check("req_cycles", rq_n, got.req_n);
    // A stray ack during DONE must be ignored; the held command re-stalls
    // right after the single DONE cycle.
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    check("stall_after_done", stall, 1);
    mem_ack = 1'b0;
    memread = 1'b0; memwrite = 1'b0;
    check("ir_after_done", ir, got.ir);
    check("mdr_after_done", mdr, got.mdr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    m_ir = '0; m_mdr = '0; m_err = '0;
    reset_n = 1'b0;
    memread = 1'b1; memwrite = 1'b0; IorD = 1'b0; IR_write = 1'b0;
    pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    check("rst_stall", stall, 0);
    check("rst_ir", ir, 0);
    check("rst_mdr", mdr, 0);
    check("rst_err", err, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    memread = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Fetch, load, store, read+write together
    do_access(1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 3, 32'h8C220004);
    check("fetch_opcode_lw", opcode, 6'h23);
    do_access(1, 0, 1, 0, 32'h40, 32'h104, 32'h0, 1, 32'hDEADBEEF);
    do_access(0, 1, 1, 0, 32'h44, 32'h200, 32'h12345678, 2, 32'h55555555);
    do_access(1, 1, 1, 1, 32'h44, 32'h208, 32'hCAFEF00D, 1, 32'hAAAAAAAA);
    // Timeout, recovery, ack on the expiry edge
    do_access(1, 0, 0, 1, 32'h48, 32'h0, 32'h0, 0, 32'h0);
    do_access(1, 0, 0, 1, 32'h4C, 32'h0, 32'h0, 2, 32'h10220003);
    do_access(1, 0, 1, 0, 32'h4C, 32'h300, 32'h0, TMO, 32'h0BADC0DE);
    // Misaligned data address
    do_access(1, 0, 1, 0, 32'h50, 32'h106, 32'h0, 1, 32'h11111111);

    // Reset in the middle of a BUSY transfer
    @(posedge clk); #1;
    memread = 1'b1; IorD = 1'b0; IR_write = 1'b1; pc = 32'h80;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_req", mem_req, 1);
    reset_n = 1'b0;
    #1;
    m_ir = '0; m_mdr = '0; m_err = '0;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_ir", ir, 0);
    check("mid_rst_mdr", mdr, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_stall", stall, 0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    memread = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("post_rst_ack_ir", ir, 0);
    check("post_rst_ack_stall", stall, 0);
    check("post_rst_ack_req", mem_req, 0);
    do_access(1, 0, 0, 1, 32'h80, 32'h0, 32'h0, 1, 32'hAC430008);

    // Random aligned traffic, including timeouts (ack_at = TMO+1)
    for (int i = 0; i < 10; i++) begin
      logic rd_r, wr_r;
      rd_r = 1'($urandom_range(0, 1));
      wr_r = ~rd_r | 1'($urandom_range(0, 1));
      do_access(rd_r, wr_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom & 32'hFFFC, $urandom & 32'hFFFC, $urandom,
                $urandom_range(1, TMO + 1), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
